carry_seg_pipe: RTL and testbench
=================================

# carry_seg_pipe

Pipelined segmented adder that splits a WIDTH-bit addition into SEG-bit slices, one slice per pipeline stage. The carry-out of each slice is registered and re-injected as the carry-in of the next slice one cycle later. It is the consumer end of the carry-init path: the chain's first carry-in is selected by the same 2-bit init code used by the carry-in mux (0, 1, external). It sits between fabric datapaths and wide counters/accumulators in the SoM vision pipeline, where a full-width ripple chain would miss timing.

## Interface
- WIDTH, 32, operand/sum width; must be a multiple of SEG.
- SEG, 8, slice width. NSEG = WIDTH/SEG stages, NSEG >= 1.
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cinit  in  2  carry-init code: 00→0, 01→1, 10→carryin, 11→0.
- carryin  in  1  external carry, used only when cinit = 10.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  (a + b + c0) mod 2^WIDTH.
- carryout  out  1  carry out of the top slice.

## Operation
- Beat accepted when in_valid && in_ready. c0 is resolved from cinit/carryin at accept and never later.
- Stage k (0..NSEG-1) holds: valid bit, registered carry, completed low slices sum[k*SEG-1:0], and pending operand slices k..NSEG-1.
- On advance, stage k computes {c, s} = a_slice[k] + b_slice[k] + carry_k (SEG+1-bit add) and writes s into slice k of the forwarded partial sum and c into the next stage's carry. Unused operand bits are dropped once consumed.
- Output register = stage NSEG-1 result: sum, carryout, out_valid.
- Flow control uses a single global enable: adv = !out_valid || out_ready. in_ready = adv. When adv = 1, all stages shift one place, and empty stages shift as bubbles. When adv = 0, all stages hold, including data and carries.
- No combinational path from in_valid to out_valid. in_ready depends only on out_valid and out_ready.
- Wrap-around: all-ones + 1 yields sum = 0, carryout = 1. No saturation.
- Reset mid-operation discards all in-flight beats. No partial result is ever emitted.

## Timing
- Reset values: out_valid = 0, sum = 0, carryout = 0, every stage valid = 0, carries = 0. in_ready = 1 during and after reset.
- Latency: a beat accepted at edge t appears with out_valid = 1 after edge t+NSEG, provided adv held.
- Throughput: 1 beat/cycle when out_ready is held high.
- out_valid && !out_ready: sum and carryout stay stable until the handshake completes (AXI-style). Stall inserts no bubbles; resumption loses no beats.
- Simultaneous in accept and out handshake in the same cycle: both occur and pipeline occupancy is unchanged.
- Critical path: one SEG+1-bit carry chain plus the enable mux.

## Configuration
- CARRY_SEG_PIPE_OVF_EN defined: adds output port ovf (1 bit, reset 0), aligned with sum.
  - ovf = signed two's-complement overflow: (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - Top-stage MSBs of a and b are carried to the last stage for this check.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package carry_seg_pkg holds:
  - cinit code localparams: CINIT_ZERO = 2'b00, CINIT_ONE = 2'b01, CINIT_EXT = 2'b10.
  - function cinit_resolve(code, ext), returning c0 (11 → 0).
  - NSEG derivation.
- Sub-module carry_seg_slice: registered SEG-bit add slice with carry in/out, enable, async reset. Instantiated NSEG times via generate.

## Test plan
- Reset: assert rst mid-stream with 3 beats in flight → out_valid = 0 immediately; after release, no stale beat emerges and in_ready = 1.
- Carry propagation, WIDTH=32, SEG=8: a = 0x00FF_FFFF, b = 0x1, cinit = 00 → sum = 0x0100_0000, carryout = 0, 4 cycles after accept.
- Init codes, a = b = 0x0: cinit 00 / 01 / 10 with carryin = 1 / 11 → sums 0, 1, 1, 0.
- Wrap: a = 0xFFFF_FFFF, b = 0, cinit = 01 → sum = 0, carryout = 1. With CARRY_SEG_PIPE_OVF_EN, a = 0x7FFF_FFFF, b = 1 → ovf = 1.
- Backpressure: stream 16 random beats with out_ready toggling pseudo-randomly → all 16 results match the reference model in order; outputs stay stable while stalled.
- Full throughput: out_ready = 1, in_valid = 1 for 20 cycles → 20 results on consecutive cycles starting at cycle NSEG.

Source files
------------

// File: rtl/carry_seg_pkg.sv
// Shared definitions for the segmented carry pipeline: carry-init codes,
// the carry-init resolver and the stage-count derivation.
package carry_seg_pkg;

  localparam logic [1:0] CINIT_ZERO = 2'b00;
  localparam logic [1:0] CINIT_ONE  = 2'b01;
  localparam logic [1:0] CINIT_EXT  = 2'b10;

  function automatic int unsigned nseg_of(input int unsigned width, input int unsigned seg);
    return width / seg;
  endfunction

  function automatic logic cinit_resolve(input logic [1:0] code, input logic ext);
    logic c0;
    case (code)
      CINIT_ONE: c0 = 1'b1;
      CINIT_EXT: c0 = ext;
      default:   c0 = 1'b0;  // CINIT_ZERO and the reserved code 2'b11
    endcase
    return c0;
  endfunction

endpackage

// File: rtl/carry_seg_pipe_slice.sv
// One registered SEG-bit add slice: {c_q, s_q} <= a_s + b_s + c_in when en,
// otherwise holds. Async active-high reset clears sum and carry.
module carry_seg_slice
  import carry_seg_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SEG-1:0] a_s,
  input  logic [SEG-1:0] b_s,
  input  logic           c_in,
  output logic [SEG-1:0] s_q,
  output logic           c_q
);

  logic [SEG-1:0] s_d;
  logic           c_d;

  always_comb begin
    s_d = s_q;
    c_d = c_q;
    if (en) begin
      {c_d, s_d} = {1'b0, a_s} + {1'b0, b_s} + {{SEG{1'b0}}, c_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/carry_seg_pipe.sv
// Pipelined segmented adder: one SEG-bit slice per stage, carries registered
// between slices. Optional signed-overflow output ovf under CARRY_SEG_PIPE_OVF_EN.
module carry_seg_pipe
  import carry_seg_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       cinit,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
`ifdef CARRY_SEG_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSEG = nseg_of(WIDTH, SEG);
  localparam int unsigned OW   = 2 * SEG;  // one {a,b} operand slice pair

  // Handshake: a beat transfers on a rising edge where valid && ready. adv is
  // the single pipeline enable; every stage shifts or holds together, so
  // in_ready depends only on out_valid/out_ready, never on in_valid.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [NSEG:0] vld_q, vld_d;
  logic          c0_q, c0_d;
  logic [NSEG:0] cy;

  always_comb begin
    vld_d = vld_q;
    c0_d  = c0_q;
    if (adv) begin
      vld_d = {vld_q[NSEG-1:0], in_valid};
      c0_d  = cinit_resolve(cinit, carryin);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c0_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      c0_q  <= c0_d;
    end
  end

  assign cy[0]     = c0_q;
  assign out_valid = vld_q[NSEG];
  assign carryout  = cy[NSEG];

  // Slice j's operands are skewed j+1 registers so they meet the carry from
  // slice j-1; its sum is then deskewed so all slices line up at the output.
  for (genvar j = 0; j < NSEG; j++) begin : g_slice
    localparam int unsigned OD = j + 1;
    localparam int unsigned SD = NSEG - 1 - j;

    logic [OD*OW-1:0] op_q, op_d, op_shift;
    logic [OW-1:0]    op_in, op_cur;
    logic [SEG-1:0]   s_q;

    assign op_in  = {a[j*SEG +: SEG], b[j*SEG +: SEG]};
    assign op_cur = op_q[OD*OW-1 -: OW];

    if (j == 0) begin : g_op1
      assign op_shift = op_in;
    end else begin : g_opn
      assign op_shift = {op_q[j*OW-1:0], op_in};
    end

    always_comb begin
      op_d = op_q;
      if (adv) op_d = op_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) op_q <= '0;
      else     op_q <= op_d;
    end

    carry_seg_slice #(.SEG(SEG)) u_slice (
      .clk  (clk),
      .rst  (rst),
      .en   (adv),
      .a_s  (op_cur[OW-1:SEG]),
      .b_s  (op_cur[SEG-1:0]),
      .c_in (cy[j]),
      .s_q  (s_q),
      .c_q  (cy[j+1])
    );

    if (SD == 0) begin : g_sum0
      assign sum[j*SEG +: SEG] = s_q;
    end else begin : g_sumn
      logic [SD*SEG-1:0] sd_q, sd_d, sd_shift;

      if (SD == 1) begin : g_sd1
        assign sd_shift = s_q;
      end else begin : g_sdn
        assign sd_shift = {sd_q[(SD-1)*SEG-1:0], s_q};
      end

      always_comb begin
        sd_d = sd_q;
        if (adv) sd_d = sd_shift;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) sd_q <= '0;
        else     sd_q <= sd_d;
      end

      assign sum[j*SEG +: SEG] = sd_q[SD*SEG-1 -: SEG];
    end

`ifdef CARRY_SEG_PIPE_OVF_EN
    if (j == NSEG - 1) begin : g_ovf
      logic [1:0] msb_q, msb_d;  // {a MSB, b MSB} aligned with the output register

      always_comb begin
        msb_d = msb_q;
        if (adv) msb_d = {op_cur[OW-1], op_cur[SEG-1]};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) msb_q <= 2'b00;
        else     msb_q <= msb_d;
      end

      assign ovf = (msb_q[1] == msb_q[0]) && (sum[WIDTH-1] != msb_q[1]);
    end
`endif
  end

endmodule

// File: tb/tb_carry_seg_pipe.sv
// Directed self-checking bench for carry_seg_pipe (WIDTH=32, SEG=8); checks
// ovf as well when CARRY_SEG_PIPE_OVF_EN is defined.
module tb_carry_seg_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEG   = 8;
  localparam int unsigned NSEG  = WIDTH / SEG;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic [1:0]       cinit     = 2'b00;
  logic             carryin   = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carryout;
`ifdef CARRY_SEG_PIPE_OVF_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH:0] exp_q[$];  // {carryout, sum}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  carry_seg_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cinit     (cinit),
    .carryin   (carryin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout)
`ifdef CARRY_SEG_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                            input logic [1:0] dc, input logic dci);
    in_valid = 1'b1;
    a        = da;
    b        = db;
    cinit    = dc;
    carryin  = dci;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                             input logic [1:0] rc, input logic rci);
    logic [WIDTH:0] c0;
    c0 = '0;
    if (rc == 2'b01 || (rc == 2'b10 && rci)) c0 = 1;
    return {1'b0, ra} + {1'b0, rb} + c0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_cmp++; if (carryout !== 1'b0) begin n_err++; $display("FAIL reset_carryout: got %b want 0", carryout); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef CARRY_SEG_PIPE_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_beat(WIDTH'(i + 1), 32'h10, 2'b01, 1'b0);
      tick();
    end
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready: got %b want 1", in_ready); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_stale cyc %0d: got %b want 0", i, out_valid); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_post_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_carry_prop();
    out_ready = 1'b1;
    drive_beat(32'h00FF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL carry_in_ready: got %b want 1", in_ready); end
    tick();
    drive_idle();
    for (int i = 1; i <= NSEG; i++) begin
      tick();
      if (i < NSEG) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_early cyc %0d: got %b want 0", i, out_valid); end
      end else begin
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL carry_latency: got %b want 1", out_valid); end
        n_cmp++; if (sum !== 32'h0100_0000) begin n_err++; $display("FAIL carry_sum: got %h want 01000000", sum); end
        n_cmp++; if (carryout !== 1'b0) begin n_err++; $display("FAIL carry_cout: got %b want 0", carryout); end
      end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL carry_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_init_codes();
    logic [1:0]       codes [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    logic             cins  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] exps  [5] = '{32'h0, 32'h1, 32'h1, 32'h0, 32'h0};
    int sent = 0;
    int got  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (sent < 5) drive_beat('0, '0, codes[sent], cins[sent]);
      else          drive_idle();
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (sum !== exps[got]) begin n_err++; $display("FAIL init_sum beat %0d: got %h want %h", got, sum, exps[got]); end
        n_cmp++; if (carryout !== 1'b0) begin n_err++; $display("FAIL init_cout beat %0d: got %b want 0", got, carryout); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    drive_idle();
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL init_count: got %0d want 5", got); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] wa   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [WIDTH-1:0] wb   [4] = '{32'h0, 32'h1, 32'h1, 32'h8000_0000};
    logic [1:0]       wc   [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
    logic [WIDTH-1:0] wsum [4] = '{32'h0, 32'h0, 32'h8000_0000, 32'h0};
    logic             wco  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef CARRY_SEG_PIPE_OVF_EN
    logic             wovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    int sent = 0;
    int got  = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) drive_beat(wa[sent], wb[sent], wc[sent], 1'b0);
      else          drive_idle();
      #1;
      if (out_valid && out_ready) begin
        n_cmp++; if (sum !== wsum[got]) begin n_err++; $display("FAIL wrap_sum beat %0d: got %h want %h", got, sum, wsum[got]); end
        n_cmp++; if (carryout !== wco[got]) begin n_err++; $display("FAIL wrap_cout beat %0d: got %b want %b", got, carryout, wco[got]); end
`ifdef CARRY_SEG_PIPE_OVF_EN
        n_cmp++; if (ovf !== wovf[got]) begin n_err++; $display("FAIL wrap_ovf beat %0d: got %b want %b", got, ovf, wovf[got]); end
`endif
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    drive_idle();
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL wrap_count: got %0d want 4", got); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0]   exp_v;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum   = '0;
    logic             prev_co    = 1'b0;
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      if (sent < 16) drive_beat($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else           drive_idle();
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_cmp++; if (out_valid !== 1'b1 || sum !== prev_sum || carryout !== prev_co) begin
          n_err++; $display("FAIL bp_stable cyc %0d: got v=%b %b/%h want v=1 %b/%h", cyc, out_valid, carryout, sum, prev_co, prev_sum);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_extra cyc %0d: got %b/%h want no result", cyc, carryout, sum);
        end else begin
          exp_v = exp_q.pop_front();
          if ({carryout, sum} !== exp_v) begin
            n_err++; $display("FAIL bp_data beat %0d: got %b/%h want %b/%h", got, carryout, sum, exp_v[WIDTH], exp_v[WIDTH-1:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, cinit, carryin));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_co    = carryout;
      tick();
    end
    drive_idle();
    out_ready = 1'b1;
    n_cmp++; if (got !== 16 || exp_q.size() != 0) begin n_err++; $display("FAIL bp_count: got %0d left %0d want 16 left 0", got, exp_q.size()); end
  endtask

  task automatic test_throughput();
    logic [WIDTH:0] exp_v;
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
      if (sent < 20) drive_beat(WIDTH'(sent) * 32'h1111_1111, 32'hF000_000F + WIDTH'(sent), 2'b01, 1'b0);
      else           drive_idle();
      #1;
      if (out_valid) begin
        n_cmp++; if (cyc !== int'(NSEG) + 1 + got) begin n_err++; $display("FAIL thru_cycle beat %0d: got %0d want %0d", got, cyc, int'(NSEG) + 1 + got); end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL thru_extra cyc %0d: got %h want no result", cyc, sum);
        end else begin
          exp_v = exp_q.pop_front();
          if ({carryout, sum} !== exp_v) begin
            n_err++; $display("FAIL thru_data beat %0d: got %b/%h want %b/%h", got, carryout, sum, exp_v[WIDTH], exp_v[WIDTH-1:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a, b, cinit, carryin));
        sent++;
      end
      tick();
    end
    drive_idle();
    n_cmp++; if (got !== 20) begin n_err++; $display("FAIL thru_count: got %0d want 20", got); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_carry_prop();
    test_init_codes();
    test_wrap();
    test_backpressure();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
